// File: rtl/lapido_pkg.sv
// Shared constants for the ALU issue sequencer: opcodes, instruction fields,
// FSM states, flag positions and the opcode-class decoder.
package lapido_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADDINC = 5'b00001;
    localparam logic [4:0] OP_BEQ    = 5'b00010;
    localparam logic [4:0] OP_INCA   = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_BNE    = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_NOT    = 5'b01001;
    localparam logic [4:0] OP_JUMP   = 5'b01010;
    localparam logic [4:0] OP_SHL    = 5'b01011;
    localparam logic [4:0] OP_SHR    = 5'b01100;
    localparam logic [4:0] OP_UND0   = 5'b01101;
    localparam logic [4:0] OP_UND1   = 5'b01110;
    localparam logic [4:0] OP_UND2   = 5'b01111;
    localparam logic [4:0] OP_ZEROS  = 5'b10000;

    localparam int OPC_LSB = 27;
    localparam int RD_LSB  = 23;
    localparam int RS_LSB  = 19;
    localparam int RT_LSB  = 15;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'd0,
        CLS_ARITH  = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_UNDEF  = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_BEQ, OP_BNE, OP_JUMP:    cls = CLS_BRANCH;
            OP_ADD, OP_ADDINC, OP_INCA: cls = CLS_ARITH;
            OP_UND0, OP_UND1, OP_UND2:  cls = CLS_UNDEF;
            default:                    cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ula_regbank.sv
// Private register bank: two combinational read ports, one synchronous write
// port; R0 always reads as zero and is never written.
module ula_regbank
    import lapido_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [NREG];

    // Register storage with synchronous clear; writes to R0 are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_r[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle issue sequencer in front of the ALU: accept, issue operands,
// sample result and flags, then commit a register write or a branch outcome.
module ula_seq
    import lapido_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        flags,
    output logic              branch_valid,
    output logic              branch_taken,
    output logic              busy
);

    seq_state_t        state_r;
    logic [4:0]        opc_r;
    logic [AW-1:0]     rd_r;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic [DATA_W-1:0] res_r;
    logic              zero_r;
    logic              carry_r;
    logic              ovf_r;

    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    op_class_t         cls_s;
    logic              we_s;
    logic              unused_bits_s;

    assign unused_bits_s = ^instr[14:0];
    assign cls_s         = op_class(opc_r);
    assign we_s          = (state_r == ST_COMMIT)
                         && ((cls_s == CLS_ARITH) || (cls_s == CLS_OTHER))
                         && (rd_r != '0);

    // Operands are read straight from the incoming word so they are ready at accept.
    ula_regbank #(
        .NREG   (NREG),
        .DATA_W (DATA_W)
    ) u_regbank (
        .clock   (clock),
        .reset   (reset),
        .we      (we_s),
        .waddr   (rd_r),
        .wdata   (res_r),
        .raddr_a (instr[RS_LSB +: AW]),
        .rdata_a (rdata_a_s),
        .raddr_b (instr[RT_LSB +: AW]),
        .rdata_b (rdata_b_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            opc_r        <= OP_ZEROS;
            rd_r         <= '0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            res_r        <= '0;
            zero_r       <= 1'b0;
            carry_r      <= 1'b0;
            ovf_r        <= 1'b0;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= OP_ZEROS;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            flags        <= 3'b000;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            branch_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opc_r       <= instr[OPC_LSB +: 5];
                        rd_r        <= instr[RD_LSB +: AW];
                        op_a_r      <= rdata_a_s;
                        op_b_r      <= rdata_b_s;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_a      <= op_a_r;
                    alu_b      <= op_b_r;
                    alu_opcode <= opc_r;
                    state_r    <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    res_r   <= alu_out;
                    zero_r  <= alu_zero;
                    carry_r <= alu_carry;
                    ovf_r   <= alu_overflow;
                    state_r <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    case (cls_s)
                        CLS_BRANCH: begin
                            branch_valid     <= 1'b1;
                            branch_taken     <= zero_r;
                            flags[FLAG_ZERO] <= zero_r;
                        end
                        CLS_ARITH: begin
                            flags[FLAG_CARRY] <= flags[FLAG_CARRY] | carry_r;
                            flags[FLAG_OVF]   <= flags[FLAG_OVF] | ovf_r;
                        end
                        default: begin
                        end
                    endcase
                    if (we_s) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_r;
                        wb_data  <= res_r;
                    end
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: a behavioural ALU answers the sequencer, issued
// words push expected commits, a negedge monitor pops and compares them.
module tb_ula_seq;

    localparam logic [4:0] B_ADD   = 5'b00000;
    localparam logic [4:0] B_BEQ   = 5'b00010;
    localparam logic [4:0] B_INCA  = 5'b00011;
    localparam logic [4:0] B_OR    = 5'b00110;
    localparam logic [4:0] B_BNE   = 5'b00111;
    localparam logic [4:0] B_XOR   = 5'b01000;
    localparam logic [4:0] B_JUMP  = 5'b01010;
    localparam logic [4:0] B_SHL   = 5'b01011;
    localparam logic [4:0] B_UND   = 5'b01101;
    localparam logic [4:0] B_ZEROS = 5'b10000;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } alu_res_t;

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        taken;
        logic [2:0]  flg;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_out, wb_data;
    logic [4:0]  alu_opcode;
    logic        alu_zero, alu_carry, alu_overflow;
    logic        wb_valid, branch_valid, branch_taken, busy;
    logic [3:0]  wb_addr;
    logic [2:0]  flags;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mreg [16];
    logic [2:0]  mflags;
    alu_res_t    ar;

    ula_seq dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .flags(flags), .branch_valid(branch_valid),
        .branch_taken(branch_taken), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic alu_res_t alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_res_t    r;
        logic [32:0] s;
        r = '0;
        s = 33'd0;
        case (op)
            B_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r.res = s[31:0];
                r.c = s[32];
                r.v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            B_INCA: begin
                s = {1'b0, a} + 33'd1;
                r.res = s[31:0];
                r.c = s[32];
                r.v = !a[31] && s[31];
            end
            B_BEQ, B_BNE: r.res = a - b;
            B_OR:         r.res = a | b;
            B_XOR:        r.res = a ^ b;
            B_SHL:        r.res = a << 1;
            default:      r.res = 32'd0;
        endcase
        r.z = (op == B_BNE) ? (r.res != 32'd0) : (r.res == 32'd0);
        return r;
    endfunction

    always_comb begin
        ar = alu_fn(alu_opcode, alu_a, alu_b);
    end
    assign alu_out      = ar.res;
    assign alu_zero     = ar.z;
    assign alu_carry    = ar.c;
    assign alu_overflow = ar.v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
        mflags = 3'b000;
    endtask

    // Reference model of one instruction; hand values override the model's result.
    task automatic model_push(input logic [31:0] w, input int acc, input logic hchk,
                              input logic [31:0] hdata, input logic [2:0] hflags,
                              output logic [31:0] ea, output logic [31:0] eb);
        logic [4:0] op;
        logic [3:0] rd, rs, rt;
        alu_res_t   r;
        exp_t       e;
        logic       wr;
        op = w[31:27];
        rd = w[26:23];
        rs = w[22:19];
        rt = w[18:15];
        ea = (rs == 4'd0) ? 32'd0 : mreg[rs];
        eb = (rt == 4'd0) ? 32'd0 : mreg[rt];
        r  = alu_fn(op, ea, eb);
        wr = 1'b0;
        e.kind = 2'b00; e.addr = rd; e.data = r.res; e.taken = r.z; e.cyc = acc + 3;
        case (op)
            B_BEQ, B_BNE, B_JUMP: begin
                mflags[0] = r.z;
                e.kind = 2'b01;
            end
            B_ADD, 5'b00001, B_INCA: begin
                mflags[1] = mflags[1] | r.c;
                mflags[2] = mflags[2] | r.v;
                wr = 1'b1;
            end
            5'b01101, 5'b01110, 5'b01111: wr = 1'b0;
            default: wr = 1'b1;
        endcase
        if (wr && rd != 4'd0) begin
            mreg[rd] = r.res;
            e.kind = 2'b10;
        end
        e.flg = mflags;
        if (hchk) begin
            e.data  = hdata;
            e.taken = hdata[0];
            e.flg   = hflags;
        end
        if (e.kind != 2'b00) exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        @(negedge clock);
        for (int g = 0; g < 40 && !instr_ready; g++) @(negedge clock);
        if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue_h(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [3:0] rt, input logic hchk, input logic [31:0] hdata,
                           input logic [2:0] hflags);
        logic [31:0] w, ea, eb;
        w = {op, rd, rs, rt, 15'd0};
        wait_ready();
        instr_valid = 1'b1;
        instr = w;
        model_push(w, cyc + 1, hchk, hdata, hflags, ea, eb);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        instr = 32'd0;
        @(negedge clock);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_opcode", {27'd0, alu_opcode}, {27'd0, op});
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
        issue_h(op, rd, rs, rt, 1'b0, 32'd0, 3'd0);
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && (wb_valid || branch_valid)) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", {30'd0, wb_valid, branch_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {30'd0, wb_valid, branch_valid}, {30'd0, mon_e.kind});
                check("latency", 32'(cyc), 32'(mon_e.cyc));
                check("flags", {29'd0, flags}, {29'd0, mon_e.flg});
                if (mon_e.kind == 2'b10) begin
                    check("wb_addr", {28'd0, wb_addr}, {28'd0, mon_e.addr});
                    check("wb_data", wb_data, mon_e.data);
                end else begin
                    check("branch_taken", {31'd0, branch_taken}, {31'd0, mon_e.taken});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w1, w2, ea, eb;
        int          acc1, acc2, lowcnt;
        logic        got;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {29'd0, wb_valid, branch_valid, branch_taken}, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_opcode", {27'd0, alu_opcode}, 32'h10);
        reset = 1'b0;

        // R1=5, R2=7, then ADD R3 = 12 with clean flags
        issue(B_ZEROS, 4'd1, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) issue(B_INCA, 4'd1, 4'd1, 4'd0);
        issue(B_ZEROS, 4'd2, 4'd0, 4'd0);
        for (int i = 0; i < 7; i++) issue(B_INCA, 4'd2, 4'd2, 4'd0);
        issue_h(B_ADD, 4'd3, 4'd1, 4'd2, 1'b1, 32'd12, 3'b000);

        // R1=R2=0x80000000: carry and overflow become sticky
        issue(B_ZEROS, 4'd1, 4'd0, 4'd0);
        issue(B_INCA, 4'd1, 4'd1, 4'd0);
        for (int i = 0; i < 31; i++) issue(B_SHL, 4'd1, 4'd1, 4'd0);
        issue_h(B_OR, 4'd2, 4'd1, 4'd1, 1'b1, 32'h8000_0000, 3'b000);
        issue_h(B_ADD, 4'd4, 4'd1, 4'd2, 1'b1, 32'd0, 3'b110);
        issue_h(B_XOR, 4'd5, 4'd1, 4'd2, 1'b1, 32'd0, 3'b110);

        // Branches with R1=R2=9
        issue(B_ZEROS, 4'd1, 4'd0, 4'd0);
        for (int i = 0; i < 9; i++) issue(B_INCA, 4'd1, 4'd1, 4'd0);
        issue_h(B_OR, 4'd2, 4'd1, 4'd1, 1'b1, 32'd9, 3'b110);
        issue_h(B_BEQ, 4'd0, 4'd1, 4'd2, 1'b1, 32'd1, 3'b111);
        issue_h(B_BNE, 4'd0, 4'd1, 4'd2, 1'b1, 32'd0, 3'b110);
        issue_h(B_JUMP, 4'd0, 4'd0, 4'd0, 1'b1, 32'd1, 3'b111);

        // rd=0 dropped, R0 reads zero, undefined opcode writes nothing
        issue(B_XOR, 4'd0, 4'd1, 4'd2);
        issue_h(B_OR, 4'd7, 4'd0, 4'd1, 1'b1, 32'd9, 3'b111);
        issue(B_UND, 4'd8, 4'd1, 4'd2);
        issue_h(B_OR, 4'd9, 4'd8, 4'd8, 1'b1, 32'd0, 3'b111);

        // instr_valid held high across two words
        w1 = {B_ADD, 4'd10, 4'd1, 4'd2, 15'd0};
        w2 = {B_ADD, 4'd11, 4'd10, 4'd1, 15'd0};
        wait_ready();
        instr_valid = 1'b1;
        instr = w1;
        acc1 = cyc + 1;
        acc2 = 0;
        lowcnt = busy ? 0 : 1;
        model_push(w1, acc1, 1'b1, 32'd18, 3'b111, ea, eb);
        @(negedge clock);
        instr = w2;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!busy) lowcnt++;
            if (instr_ready) begin
                acc2 = cyc + 1;
                model_push(w2, acc2, 1'b1, 32'd27, 3'b111, ea, eb);
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        instr = 32'd0;
        check("second_accept", {31'd0, got}, 32'd1);
        check("accept_spacing", 32'(acc2 - acc1), 32'd4);
        check("busy_low_cycles", 32'(lowcnt), 32'd2);

        // reset during SAMPLE discards the instruction
        wait_ready();
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(negedge clock);
        check("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
        instr_valid = 1'b1;
        instr = {B_OR, 4'd6, 4'd1, 4'd2, 15'd0};
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        instr = 32'd0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_opcode", {27'd0, alu_opcode}, 32'h10);
        check("mid_rst_flags", {29'd0, flags}, 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clock);
        issue_h(B_OR, 4'd7, 4'd6, 4'd6, 1'b1, 32'd0, 3'b000);

        for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
